// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - MEM-stage 32-bit load/store to 16-bit async SRAM sequencer
//
// Purpose: each 32-bit load or store is split into two halfword SRAM accesses,
// low half then high half. Each half is held on the bus for WAIT_CYCLES cycles.
// ready is held low while an access is in flight, and the pipeline uses it as a freeze.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN        load / store request from the MEM stage
//   address, write_data       byte address (ALU result), store value
//   read_data                 load result, held until the next load completes
//   ready                     1 = pipeline may advance, 0 = freeze
//   SRAM_ADDR                 SRAM halfword address
//   SRAM_DQ_out, SRAM_DQ_oe   write data and data-bus drive enable
//   SRAM_DQ_in                read data from the SRAM
//   SRAM_WE_N, SRAM_OE_N      active-low write / output enables
module sram_mem_controller #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_DQ_out,
  input  logic [15:0]       SRAM_DQ_in,
  output logic              SRAM_DQ_oe,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  // Gray-coded so that every transition flips exactly one state bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b11,
    DONE = 2'b10
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                op_write;
  logic [ADDR_W-2:0]   word_idx;
  logic [31:0]         wdata;
  logic                we_n_q;
  logic                oe_n_q;
  logic                dq_oe_q;

  logic                req;
  logic                last;
  logic [31:0]         addr_off;
  logic                unused_addr_bits;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign last     = (cnt == LAST_CNT);
  assign addr_off = address - 32'd1024;
  // The out-of-range bits of the offset are dropped, so the address wraps modulo 2^ADDR_W.
  assign unused_addr_bits = &{1'b0, addr_off[31:ADDR_W+1], addr_off[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      word_idx  <= '0;
      wdata     <= '0;
      read_data <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= LOW;
            cnt      <= '0;
            // A store takes priority when both requests are present.
            op_write <= MEM_W_EN;
            word_idx <= addr_off[ADDR_W:2];
            wdata    <= write_data;
            we_n_q   <= ~MEM_W_EN;
            oe_n_q   <= MEM_W_EN;
            dq_oe_q  <= MEM_W_EN;
          end
        end
        LOW: begin
          if (last) begin
            state <= HIGH;
            cnt   <= '0;
            if (!op_write) read_data[15:0] <= SRAM_DQ_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (last) begin
            state   <= DONE;
            cnt     <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            if (!op_write) read_data[31:16] <= SRAM_DQ_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // DONE: the request still present here belongs to the finished instruction.
          state <= IDLE;
        end
      endcase
    end
  end

  // The strobes come straight from flops, so the SRAM never sees a decode glitch.
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_DQ_oe = dq_oe_q;

  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = 16'h0000;
    case (state)
      LOW: begin
        SRAM_ADDR = {word_idx, 1'b0};
        if (op_write) SRAM_DQ_out = wdata[15:0];
      end
      HIGH: begin
        SRAM_ADDR = {word_idx, 1'b1};
        if (op_write) SRAM_DQ_out = wdata[31:16];
      end
      default: ;
    endcase
  end

  assign ready = (state == DONE) | ((state == IDLE) & ~req);

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle memory controller for the MEM stage of the 5-stage MIPS pipeline. It converts a single-cycle 32-bit load/store request (MEM_R_EN/MEM_W_EN, ALU_result address, ST_val data) into two sequenced 16-bit accesses on an external asynchronous SRAM. While an access is in flight it drives `ready` low, which the pipeline uses as a freeze for all stage registers and the PC.

## Interface
- `ADDR_W`, 18: SRAM halfword address width.
- `WAIT_CYCLES`, 2: cycles each halfword access is held on the SRAM bus; legal range ≥1.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `MEM_R_EN`  in  1  load request from the MEM stage.
- `MEM_W_EN`  in  1  store request from the MEM stage.
- `address`  in  32  byte address, which is the ALU result.
- `write_data`  in  32  store value, which is ST_val.
- `read_data`  out  32  load result, held until the next load completes.
- `ready`  out  1  high means the pipeline may advance; low means freeze.
- `SRAM_ADDR`  out  ADDR_W  SRAM halfword address.
- `SRAM_DQ_out`  out  16  write data to the SRAM.
- `SRAM_DQ_in`  in  16  read data from the SRAM.
- `SRAM_DQ_oe`  out  1  drive enable for the SRAM data bus.
- `SRAM_WE_N`  out  1  active-low write enable.
- `SRAM_OE_N`  out  1  active-low output enable.

## Operation
**Address mapping**
- Word index = (address − 1024) >> 2.
- Low half: SRAM_ADDR = {word index, 1'b0}, carrying data[15:0].
- High half: SRAM_ADDR = {word index, 1'b1}, carrying data[31:16].
- Take the result modulo 2^ADDR_W. There is no range check.

**FSM states: IDLE, LOW, HIGH, DONE**
- IDLE: on the next edge, if MEM_W_EN or MEM_R_EN is high, go to LOW. On the same edge:
  - latch the operation type (write if MEM_W_EN, else read);
  - latch the word index;
  - latch write_data.
- If MEM_R_EN and MEM_W_EN are high together, perform the write; read_data stays unchanged.
- LOW and HIGH: a wait counter (width clog2(WAIT_CYCLES+1)) clears on state entry and increments each cycle. On its last cycle (count = WAIT_CYCLES−1), advance LOW→HIGH or HIGH→DONE.
- Read in LOW or HIGH: SRAM_OE_N=0 and SRAM_DQ_oe=0. On the last cycle's edge, capture SRAM_DQ_in into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
- Write in LOW or HIGH: SRAM_WE_N=0 and SRAM_DQ_oe=1. SRAM_DQ_out carries the latched half.
- DONE: lasts exactly one cycle, then return to IDLE unconditionally. A request still asserted in DONE is the completed instruction and must not retrigger.

**`ready` (combinational)**
- 1 in DONE.
- 1 in IDLE with no request.
- 0 in IDLE with a request, and 0 in LOW and HIGH.

**Idle outputs**
- Outside LOW/HIGH: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0.
- SRAM_ADDR and SRAM_DQ_out are decoded from the state plus latches, and are 0 in IDLE and DONE.
- A write never changes read_data.

## Timing
**Reset values**
- state = IDLE; counter, latches and read_data = 0.
- SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
- ready = 1 when no request is present.

**Latency**
- Request first seen in cycle 0 (IDLE).
- LOW occupies cycles 1..W; HIGH occupies cycles W+1..2W.
- DONE is cycle 2W+1, with ready=1 and read_data valid.
- ready is low for 2W+1 consecutive cycles, so W=2 gives 5 low cycles and ready high in cycle 5.

**Back-to-back requests**
- The edge ending DONE advances the pipeline.
- A new request present in the following IDLE cycle starts immediately.
- There is exactly one IDLE cycle between accesses.

**Reset mid-operation**
- rst forces IDLE asynchronously.
- SRAM_WE_N and SRAM_OE_N deassert in the same cycle, with no wait for a clock.
- Any partial write is abandoned; read_data clears to 0.

**Glitch-free control**
- SRAM_WE_N must not glitch low in IDLE or DONE; decode it from registered state only.

## Test plan
- **Reset:** rst pulse with no request → all SRAM strobes inactive, ready=1, read_data=0.
- **Write, W=2:** write 0x12345678 at address 1024 → ready low in cycles 0–4 and high in cycle 5.
  - Cycles 1–2: SRAM_ADDR=0, DQ_out=0x5678, WE_N=0.
  - Cycles 3–4: SRAM_ADDR=1, DQ_out=0x1234, WE_N=0.
  - OE_N stays 1 throughout.
- **Read-back:** SRAM model holds the previous write; read at address 1024 → OE_N=0 in cycles 1–4, WE_N=1, read_data=0x12345678 in cycle 5.
- **Held request:** request held high through DONE → no retrigger; held for one more cycle → second access starts in the IDLE cycle after DONE. Address 1028 → SRAM_ADDR 2 then 3.
- **Reset in HIGH:** rst asserted during cycle 3 of a write → WE_N=1 and DQ_oe=0 immediately, state IDLE, ready=1 once the request is dropped.
- **Simultaneous R and W:** MEM_R_EN and MEM_W_EN both high with read_data=0xCAFEBABE → write sequence performed, read_data remains 0xCAFEBABE. Repeat with WAIT_CYCLES=1 → 3 low cycles.
